regfile24_wb_arbiter: RTL

Write-port controller for the 32×24-bit core register file. It clears all 32 registers after reset, then shares the file's single write port among NREQ writeback requesters using round-robin arbitration with valid/ready handshakes. It also keeps a per-register pending (busy) scoreboard for the issue stage. It sits between the execution/load writeback paths and the register file write port.

---
 rtl/regfile24_wb_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile24_wb_arbiter.sv
// Write-port controller for the 32x24 register file: post-reset clear sequence,
// round-robin arbitration of writeback requesters, and a pending-register scoreboard.
module regfile24_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 core_clock_i,
  input  logic                 core_reset_n_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*5-1:0]    req_dest_i,
  input  logic [NREQ*24-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_dest_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_dest_o,
  output logic [23:0]          rf_data_o,
  output logic [31:0]          busy_o,
  output logic                 init_done_o
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        r_state;
  logic [4:0]    r_cnt;
  logic [PW-1:0] r_ptr;

  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_xfer;
  logic [4:0]    w_dest;
  logic [23:0]   w_data;
  logic [31:0]   w_busy_nxt;
  int            w_t;

  // Scan from the farthest offset down to the pointer so the nearest valid
  // requester (searching upward from r_ptr) is the last one to claim the grant.
  always_comb begin
    w_xfer = 1'b0;
    w_gidx = '0;
    w_idx  = '0;
    w_t    = 0;
    if (r_state == S_RUN) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        w_t = int'(r_ptr) + i;
        if (w_t >= NREQ) w_t = w_t - NREQ;
        w_idx = PW'(w_t);
        if (req_valid_i[w_idx]) begin
          w_xfer = 1'b1;
          w_gidx = w_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (w_xfer) req_ready_o[w_gidx] = 1'b1;
  end

  assign w_dest    = req_dest_i[int'(w_gidx)*5 +: 5];
  assign w_data    = req_data_i[int'(w_gidx)*24 +: 24];
  assign w_ptr_nxt = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

  // Clear on commit first, then set on issue, so a same-cycle issue wins.
  always_comb begin
    w_busy_nxt = busy_o;
    if (rf_we_o)       w_busy_nxt[rf_dest_o]    = 1'b0;
    if (issue_valid_i) w_busy_nxt[issue_dest_i] = 1'b1;
  end

  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ptr       <= '0;
      rf_we_o     <= 1'b0;
      rf_dest_o   <= '0;
      rf_data_o   <= '0;
      busy_o      <= '0;
      init_done_o <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          rf_we_o   <= 1'b1;
          rf_dest_o <= r_cnt;
          rf_data_o <= '0;
          r_cnt     <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            init_done_o <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          busy_o <= w_busy_nxt;
          if (w_xfer) begin
            rf_we_o   <= 1'b1;
            rf_dest_o <= w_dest;
            rf_data_o <= w_data;
            r_ptr     <= w_ptr_nxt;
          end else begin
            rf_we_o <= 1'b0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule
